// File: rtl/alu_led_reader.sv
// -----------------------------------------------------------------------------
// alu_led_reader
//
// On-chip reader for the ALU top-level switch/LED interface. Drives the operand
// select, operation code and LED window select in place of the board switches.
// It then sweeps the five LED windows (F bytes 0..3, then flags) and rebuilds
// the 32-bit result F and the 4 flag bits from the 8-bit LED bus.
//
// Each window is given SETTLE_CYCLES cycles to propagate through the ALU top.
// It is then sampled for one cycle. Sampled bytes collect in a shadow register.
// The shadow register is published to result/flags only when the sweep finishes.
//
// Ports
//   clk       : system clock, rising edge
//   rst       : asynchronous, active-high reset
//   start     : request one read transaction (honoured only when idle)
//   ab_sel    : operand-pair select, copied to AB_SW on an accepted start
//   alu_op    : ALU operation code, copied to ALU_OP on an accepted start
//   LED       : ALU top LED bus (combinational function of the switch outputs)
//   AB_SW     : operand select driven to the ALU top
//   ALU_OP    : operation code driven to the ALU top
//   F_LED_SW  : LED window select, 0..3 = F byte 0..3, 4 = flags
//   busy      : high from the accepted start through the done cycle
//   done      : one-cycle pulse; result/flags were just updated
//   result    : reassembled F, {byte3,byte2,byte1,byte0}
//   flags     : LED[3:0] seen with window 4 selected ({SF,OF,CF,ZF})
// -----------------------------------------------------------------------------
module alu_led_reader #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  ab_sel,
  input  logic [3:0]  alu_op,
  input  logic [7:0]  LED,
  output logic [2:0]  AB_SW,
  output logic [3:0]  ALU_OP,
  output logic [2:0]  F_LED_SW,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic [3:0]  flags
);

  localparam int                CNT_W    = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [2:0]        IDX_FLAGS = 3'd4;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    DONE
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [2:0]        idx;
  logic [31:0]       shadow;

  logic settle_end;
  logic last_field;

  assign settle_end = (cnt == CNT_LAST);
  assign last_field = (idx == IDX_FLAGS);

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  // NOTE: the default before the case guarantees every path assigns
  // state_nxt, so no latch is inferred.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start)      state_nxt = SETTLE;
      SETTLE:  if (settle_end) state_nxt = SAMPLE;
      SAMPLE:  state_nxt = last_field ? DONE : SETTLE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath and registered outputs. Every output is a flop, so there is no
  // combinational path from LED to any output.
  // NOTE: the shadow register is reset along with everything else. That keeps
  // a transaction aborted by reset from leaving stale bytes behind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      AB_SW    <= '0;
      ALU_OP   <= '0;
      F_LED_SW <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      flags    <= '0;
      cnt      <= '0;
      idx      <= '0;
      shadow   <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            AB_SW    <= ab_sel;
            ALU_OP   <= alu_op;
            F_LED_SW <= 3'd0;
            idx      <= 3'd0;
            cnt      <= '0;
            busy     <= 1'b1;
          end
        end

        SETTLE: begin
          if (!settle_end) cnt <= cnt + 1'b1;
        end

        SAMPLE: begin
          if (!last_field) begin
            unique case (idx[1:0])
              2'd0: shadow[7:0]   <= LED;
              2'd1: shadow[15:8]  <= LED;
              2'd2: shadow[23:16] <= LED;
              2'd3: shadow[31:24] <= LED;
              default: ;
            endcase
            idx      <= idx + 3'd1;
            F_LED_SW <= idx + 3'd1;
            cnt      <= '0;
          end else begin
            // Flags are the last window sampled. They go straight to the
            // output on the same edge that publishes the collected F bytes.
            result <= shadow;
            flags  <= LED[3:0];
            done   <= 1'b1;
          end
        end

        DONE: begin
          busy <= 1'b0;
        end

        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_led_reader.sv
// -----------------------------------------------------------------------------
// tb_alu_led_reader
//
// Directed bench for alu_led_reader. Each DUT is paired with a stub ALU top.
// The stub presents byte F_LED_SW of a stub F value on LED, or the stub flags
// when window 4 is selected.
// Two DUTs are built: the default SETTLE_CYCLES=2, and SETTLE_CYCLES=1.
// -----------------------------------------------------------------------------
module tb_alu_led_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;

  // DUT with default settle time
  logic        start;
  logic [2:0]  ab_sel;
  logic [3:0]  alu_op;
  logic [7:0]  led;
  logic [2:0]  ab_sw;
  logic [3:0]  alu_op_o;
  logic [2:0]  f_led_sw;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [3:0]  flags;
  logic [31:0] stub_f;
  logic [3:0]  stub_flags;

  // DUT with SETTLE_CYCLES = 1
  logic        start2;
  logic [7:0]  led2;
  logic [2:0]  ab_sw2;
  logic [3:0]  alu_op2;
  logic [2:0]  f_led_sw2;
  logic        busy2;
  logic        done2;
  logic [31:0] result2;
  logic [3:0]  flags2;
  logic [31:0] stub_f2;
  logic [3:0]  stub_flags2;

  int total = 0;
  int bad   = 0;

  function automatic logic [7:0] stub_led(input logic [31:0] f, input logic [3:0] fl,
                                          input logic [2:0] sel);
    case (sel)
      3'd0:    return f[7:0];
      3'd1:    return f[15:8];
      3'd2:    return f[23:16];
      3'd3:    return f[31:24];
      3'd4:    return {4'b0000, fl};
      default: return 8'hEE;
    endcase
  endfunction

  always_comb led  = stub_led(stub_f,  stub_flags,  f_led_sw);
  always_comb led2 = stub_led(stub_f2, stub_flags2, f_led_sw2);

  alu_led_reader dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .ab_sel   (ab_sel),
    .alu_op   (alu_op),
    .LED      (led),
    .AB_SW    (ab_sw),
    .ALU_OP   (alu_op_o),
    .F_LED_SW (f_led_sw),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .flags    (flags)
  );

  alu_led_reader #(.SETTLE_CYCLES(1)) dut2 (
    .clk      (clk),
    .rst      (rst),
    .start    (start2),
    .ab_sel   (3'd6),
    .alu_op   (4'd7),
    .LED      (led2),
    .AB_SW    (ab_sw2),
    .ALU_OP   (alu_op2),
    .F_LED_SW (f_led_sw2),
    .busy     (busy2),
    .done     (done2),
    .result   (result2),
    .flags    (flags2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One transaction on the default DUT. lat is the number of edges from the
  // accept edge to the edge that raised done (-1 if done never came). The task
  // returns one edge after done, with the DUT back in IDLE.
  task automatic run1(input logic [2:0] ab, input logic [3:0] op, output int lat);
    @(negedge clk);
    ab_sel = ab;
    alu_op = op;
    start  = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = n;
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int dcount;
    int w;

    rst         = 1'b1;
    start       = 1'b0;
    start2      = 1'b0;
    ab_sel      = '0;
    alu_op      = '0;
    stub_f      = 32'h12345678;
    stub_flags  = 4'hA;
    stub_f2     = 32'h00A5005A;
    stub_flags2 = 4'h3;

    // ---------------- reset state ----------------
    #1;
    check("rst_ab_sw",  ab_sw,    0);
    check("rst_alu_op", alu_op_o, 0);
    check("rst_fsel",   f_led_sw, 0);
    check("rst_busy",   busy,     0);
    check("rst_done",   done,     0);
    check("rst_result", result,   0);
    check("rst_flags",  flags,    0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // ---------------- 1: basic sweep, per-edge timing ----------------
    @(negedge clk);
    ab_sel = 3'b001;
    alu_op = 4'b0010;
    start  = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check("t1_ab_sw",  ab_sw,    1);
    check("t1_alu_op", alu_op_o, 2);
    check("t1_busy0",  busy,     1);
    check("t1_fsel0",  f_led_sw, 0);
    check("t1_done0",  done,     0);
    for (int k = 1; k <= 15; k++) begin
      @(posedge clk);
      #1;
      check("t1_fsel", f_led_sw, (k / 3 > 4) ? 4 : k / 3);
      check("t1_done", done, (k == 15) ? 1 : 0);
      check("t1_busy", busy, 1);
      if (k < 15) check("t1_result_hold", result, 0);
    end
    check("t1_result", result, 32'h12345678);
    check("t1_flags",  flags,  4'hA);
    @(posedge clk);
    #1;
    check("t1_done_end", done, 0);
    check("t1_busy_end", busy, 0);

    // ---------------- 2: all-ones then all-zeros ----------------
    stub_f     = 32'hFFFFFFFF;
    stub_flags = 4'hF;
    run1(3'd4, 4'd5, lat);
    check("t2a_lat",    lat,    15);
    check("t2a_result", result, 32'hFFFFFFFF);
    check("t2a_flags",  flags,  4'hF);
    stub_f     = 32'h0;
    stub_flags = 4'h0;
    repeat (5) @(posedge clk);
    #1;
    check("t2_hold_result", result, 32'hFFFFFFFF);
    check("t2_hold_flags",  flags,  4'hF);
    run1(3'd4, 4'd5, lat);
    check("t2b_lat",    lat,    15);
    check("t2b_result", result, 32'h0);
    check("t2b_flags",  flags,  4'h0);

    // ---------------- 3: start held high, back-to-back ----------------
    stub_f     = 32'h0BADBEEF;
    stub_flags = 4'h5;
    @(negedge clk);
    ab_sel = 3'd1;
    alu_op = 4'd3;
    start  = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 55; n++) begin
      @(posedge clk);
      #1;
      check("t3_done", done, (n == 15 || n == 32 || n == 49) ? 1 : 0);
      check("t3_busy", busy, (n == 16 || n == 33 || n == 50) ? 0 : 1);
    end
    start = 1'b0;
    w = 0;
    while (busy && w < 40) begin
      @(posedge clk);
      #1;
      w++;
    end
    check("t3_drain_busy", busy,   0);
    check("t3_result",     result, 32'h0BADBEEF);
    check("t3_flags",      flags,  4'h5);

    // ---------------- 4: start during a transaction is ignored ----------------
    @(negedge clk);
    ab_sel = 3'b010;
    alu_op = 4'd4;
    start  = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    dcount = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (n == 5) begin
        start  = 1'b1;
        ab_sel = 3'b111;
      end
      if (n == 6) start = 1'b0;
      if (n == 10) check("t4_ab_sw_mid", ab_sw, 3'b010);
      if (done) dcount++;
    end
    check("t4_ab_sw_end", ab_sw,  3'b010);
    check("t4_dones",     dcount, 1);
    check("t4_busy_end",  busy,   0);

    // ---------------- 5: reset mid-transaction ----------------
    stub_f     = 32'hCAFEF00D;
    stub_flags = 4'h6;
    @(negedge clk);
    ab_sel = 3'd5;
    alu_op = 4'd9;
    start  = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (8) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("t5_ab_sw",  ab_sw,    0);
    check("t5_alu_op", alu_op_o, 0);
    check("t5_fsel",   f_led_sw, 0);
    check("t5_busy",   busy,     0);
    check("t5_done",   done,     0);
    check("t5_result", result,   0);
    check("t5_flags",  flags,    0);
    dcount = 0;
    for (int n = 0; n < 3; n++) begin
      @(posedge clk);
      #1;
      if (done) dcount++;
    end
    @(negedge clk);
    rst = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk);
      #1;
      if (done) dcount++;
    end
    check("t5_no_done",      dcount, 0);
    check("t5_result_after", result, 0);
    run1(3'd5, 4'd9, lat);
    check("t5_lat",    lat,    15);
    check("t5_result2", result, 32'hCAFEF00D);
    check("t5_flags2",  flags,  4'h6);

    // ---------------- 6: SETTLE_CYCLES = 1 build ----------------
    @(negedge clk);
    start2 = 1'b1;
    @(posedge clk);
    #1 start2 = 1'b0;
    check("t6_busy", busy2, 1);
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (done2) begin
        lat = n;
        break;
      end
    end
    check("t6_lat",    lat,     10);
    check("t6_result", result2, 32'h00A5005A);
    check("t6_flags",  flags2,  4'h3);
    check("t6_ab_sw",  ab_sw2,  3'd6);
    check("t6_alu_op", alu_op2, 4'd7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
